// File: rtl/cpu_run_pkg.sv
// Shared definitions for the CPU run controller.
//   run_state_e : controller FSM states (IDLE, RUN, STEP1, HALT)
//   run_mode_e  : run modes latched on start (FREE, COUNT, STEP)
//   decode_mode : maps the raw 2-bit mode input; the reserved code runs as FREE
package cpu_run_pkg;

  localparam int unsigned BP_ID_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP1 = 2'd2,
    ST_HALT  = 2'd3
  } run_state_e;

  typedef enum logic [1:0] {
    MODE_FREE  = 2'b00,
    MODE_COUNT = 2'b01,
    MODE_STEP  = 2'b10
  } run_mode_e;

  function automatic run_mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   return MODE_COUNT;
      2'b10:   return MODE_STEP;
      default: return MODE_FREE;
    endcase
  endfunction

endpackage

// File: rtl/rc_bp_match.sv
// Breakpoint comparator bank (purely combinational).
//   i_pc       : current CPU program counter
//   i_bp_addr  : flattened breakpoint addresses, entry 0 in the LSBs
//   i_bp_valid : per-entry enable
//   o_hit      : at least one valid entry equals i_pc
//   o_idx      : lowest-numbered matching entry (0 when no hit)
module rc_bp_match
  import cpu_run_pkg::*;
#(
  parameter int unsigned PC_W   = 16,
  parameter int unsigned NUM_BP = 2
) (
  input  logic [PC_W-1:0]        i_pc,
  input  logic [NUM_BP*PC_W-1:0] i_bp_addr,
  input  logic [NUM_BP-1:0]      i_bp_valid,
  output logic                   o_hit,
  output logic [BP_ID_W-1:0]     o_idx
);

  logic               w_found;
  logic [BP_ID_W-1:0] w_idx;

  // Ascending scan; the first match locks out higher entries.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < NUM_BP; i++) begin
      if (!w_found && i_bp_valid[i] && (i_bp_addr[i*PC_W +: PC_W] == i_pc)) begin
        w_found = 1'b1;
        w_idx   = BP_ID_W'(i);
      end
    end
  end

  assign o_hit = w_found;
  assign o_idx = w_idx;

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: generates a single registered CPU clock enable.
//   Clock, Reset      : rising-edge clock, synchronous active-high reset
//   start, stop, step : begin/resume, force halt, single enable cycle request
//   mode              : 00 FREE, 01 COUNT, 10 STEP, 11 treated as FREE
//   run_len           : enable-cycle budget for COUNT mode
//   pc, bp_addr,
//   bp_valid          : PC breakpoint inputs, checked while cpu_en is high
//   cpu_en            : CPU clock enable (high in RUN and STEP1)
//   halted            : high in IDLE and HALT
//   done              : pulse with the first HALT cycle after COUNT expiry
//   bp_hit, bp_id     : breakpoint halt pulse and held matching index
//   cycle_count       : saturating count of cpu_en cycles
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned PC_W   = 16,
  parameter int unsigned NUM_BP = 2
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   step,
  input  logic [1:0]             mode,
  input  logic [CNT_W-1:0]       run_len,
  input  logic [PC_W-1:0]        pc,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_valid,
  output logic                   cpu_en,
  output logic                   halted,
  output logic                   done,
  output logic                   bp_hit,
  output logic [2:0]             bp_id,
  output logic [CNT_W-1:0]       cycle_count
);

  run_state_e         r_state;
  run_mode_e          r_mode;
  logic [CNT_W-1:0]   r_remaining;
  logic [CNT_W-1:0]   r_cycle_count;
  logic               r_cpu_en;
  logic               r_halted;
  logic               r_done;
  logic               r_bp_hit;
  logic [2:0]         r_bp_id;

  run_state_e         w_next_state;
  run_mode_e          w_start_mode;
  logic               w_bp_match;
  logic [BP_ID_W-1:0] w_bp_idx;
  logic               w_go;
  logic               w_load_start;
  logic               w_reload;
  logic               w_dec;
  logic               w_done_set;
  logic               w_bp_set;

  rc_bp_match #(
    .PC_W   (PC_W),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .i_pc       (pc),
    .i_bp_addr  (bp_addr),
    .i_bp_valid (bp_valid),
    .o_hit      (w_bp_match),
    .o_idx      (w_bp_idx)
  );

  assign w_start_mode = decode_mode(mode);
  // start is ignored whenever stop is present in the same cycle
  assign w_go         = start && !stop;

  always_comb begin
    w_next_state = r_state;
    w_load_start = 1'b0;
    w_reload     = 1'b0;
    w_dec        = 1'b0;
    w_done_set   = 1'b0;
    w_bp_set     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_load_start = 1'b1;
          if (w_start_mode == MODE_STEP) begin
            w_next_state = ST_HALT;
          end else if ((w_start_mode == MODE_COUNT) && (run_len == '0)) begin
            // Empty budget: expire immediately without ever enabling the CPU
            w_next_state = ST_HALT;
            w_done_set   = 1'b1;
          end else begin
            w_next_state = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Every COUNT RUN cycle consumes budget, even one cut short by stop or
        // a breakpoint, so the next start reloads once the budget reaches zero.
        w_dec = (r_mode == MODE_COUNT) && (r_remaining != '0);
        if (stop) begin
          w_next_state = ST_HALT;
        end else if (w_bp_match) begin
          w_next_state = ST_HALT;
          w_bp_set     = 1'b1;
        end else if ((r_mode == MODE_COUNT) && (r_remaining == CNT_W'(1))) begin
          w_next_state = ST_HALT;
          w_done_set   = 1'b1;
        end
      end
      ST_STEP1: begin
        w_next_state = ST_HALT;
        w_bp_set     = !stop && w_bp_match;
      end
      ST_HALT: begin
        if (w_go) begin
          if ((r_mode == MODE_COUNT) && (r_remaining == '0)) begin
            w_reload = 1'b1;
            if (run_len == '0) begin
              w_done_set = 1'b1;
            end else begin
              w_next_state = ST_RUN;
            end
          end else begin
            w_next_state = ST_RUN;
          end
        end else if (step) begin
          w_next_state = ST_STEP1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state       <= ST_IDLE;
      r_mode        <= MODE_FREE;
      r_remaining   <= '0;
      r_cycle_count <= '0;
      r_cpu_en      <= 1'b0;
      r_halted      <= 1'b1;
      r_done        <= 1'b0;
      r_bp_hit      <= 1'b0;
      r_bp_id       <= '0;
    end else begin
      r_state  <= w_next_state;
      r_cpu_en <= (w_next_state == ST_RUN) || (w_next_state == ST_STEP1);
      r_halted <= (w_next_state == ST_IDLE) || (w_next_state == ST_HALT);
      r_done   <= w_done_set;
      r_bp_hit <= w_bp_set;
      if (w_bp_set) begin
        r_bp_id <= w_bp_idx;
      end

      if (w_load_start) begin
        r_mode      <= w_start_mode;
        r_remaining <= run_len;
      end else if (w_reload) begin
        r_remaining <= run_len;
      end else if (w_dec) begin
        r_remaining <= r_remaining - CNT_W'(1);
      end

      if (w_load_start) begin
        r_cycle_count <= '0;
      end else if (r_cpu_en && (r_cycle_count != '1)) begin
        r_cycle_count <= r_cycle_count + CNT_W'(1);
      end
    end
  end

  assign cpu_en      = r_cpu_en;
  assign halted      = r_halted;
  assign done        = r_done;
  assign bp_hit      = r_bp_hit;
  assign bp_id       = r_bp_id;
  assign cycle_count = r_cycle_count;

endmodule
